// File: rtl/debug_merge_pkg.sv
// Shared types and constants for the debug stream merger.
package debug_merge_pkg;

  typedef enum logic [1:0] {IDLE, PFX_ID, PFX_COL, STREAM} state_e;

  localparam int         ASCII_WIDTH = 7;
  localparam logic [6:0] ASCII_COLON = 7'h3A;
  localparam logic [6:0] DEFAULT_EOL = 7'h0A;

  // Nibble to uppercase ASCII hex digit.
  function automatic logic [6:0] hex_to_ascii(input logic [3:0] v);
    return (v < 4'd10) ? (7'h30 + {3'b000, v}) : (7'h37 + {3'b000, v});
  endfunction

endpackage

// File: rtl/ascii_fifo.sv
// Per-channel character FIFO. A push while full is accepted only when a
// pop happens in the same cycle; the caller tracks drops.
module ascii_fifo #(
  parameter int DATA_WIDTH = 7,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_q, rd_q;
  logic                  wr_en, rd_en;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rd_en   = pop_i && !empty_o;
  assign rdata_o = mem[rd_q[AW-1:0]];

  // Storage needs no reset; emptiness is defined by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= wdata_i;
  end

  // Read/write pointers with wrap bit.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/debug_stream_merger.sv
// Merges per-channel debug character streams into one output stream.
// The grant is held for a whole line (until EOL or idle timeout) so lines
// from different sources never interleave; an optional "<id>:" tag leads
// each line.
module debug_stream_merger
  import debug_merge_pkg::*;
#(
  parameter int                  CHANNELS     = 4,
  parameter int                  DATA_WIDTH   = ASCII_WIDTH,
  parameter int                  FIFO_DEPTH   = 16,
  parameter logic [DATA_WIDTH-1:0] EOL_CHAR   = DATA_WIDTH'(DEFAULT_EOL),
  parameter int                  IDLE_TIMEOUT = 256,
  parameter bit                  PREFIX_EN    = 1'b1
) (
  input  logic                           clk,
  input  logic                           res_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ascii_c_in,
  input  logic [CHANNELS-1:0]            ascii_s_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           data_out_valid,
  input  logic                           buffer_full,
  output logic [CHANNELS-1:0]            overflow,
  output logic                           busy
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);

  state_e                               state_q, state_d;
  logic [PW-1:0]                        grant_q, grant_d, rr_ptr_q, rr_ptr_d, next_ptr;
  logic [CW-1:0]                        idle_cnt_q, idle_cnt_d;
  logic [DATA_WIDTH-1:0]                data_q, emit_char;
  logic                                 valid_q, emit;
  logic [CHANNELS-1:0]                  ovf_q, ovf_d;

  logic [CHANNELS-1:0]                  full, empty, pop;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]  rdata;
  logic                                 arb_found;
  logic [PW-1:0]                        arb_idx;
  logic [DATA_WIDTH-1:0]                grant_data;
  logic                                 grant_empty;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    ascii_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .res_n   (res_n),
      .push_i  (ascii_s_in[g]),
      .wdata_i (ascii_c_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop_i   (pop[g]),
      .rdata_o (rdata[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  assign grant_data     = rdata[grant_q];
  assign grant_empty    = empty[grant_q];
  assign next_ptr       = (int'(grant_q) == CHANNELS - 1) ? '0 : grant_q + 1'b1;
  assign ovf_d          = ovf_q | (ascii_s_in & full & ~pop);
  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign overflow       = ovf_q;
  assign busy           = (state_q != IDLE) || !(&empty);

  // Round-robin search: first non-empty channel at or after rr_ptr.
  always_comb begin
    int c;
    c         = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      c = int'(rr_ptr_q) + k;
      if (c >= CHANNELS) c = c - CHANNELS;
      if (!arb_found && !empty[c]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(c);
      end
    end
  end

  // Next-state: grant held per line, released on EOL or idle timeout.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      IDLE: if (arb_found) begin
        grant_d    = arb_idx;
        idle_cnt_d = '0;
        state_d    = PREFIX_EN ? PFX_ID : STREAM;
      end
      PFX_ID:  if (!buffer_full) state_d = PFX_COL;
      PFX_COL: if (!buffer_full) state_d = STREAM;
      STREAM: begin
        if (!grant_empty) begin
          if (!buffer_full) begin
            idle_cnt_d = '0;
            if (grant_data == EOL_CHAR) begin
              state_d  = IDLE;
              rr_ptr_d = next_ptr;
            end
          end
        end else begin
          if (idle_cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
          if (idle_cnt_q != CW'(IDLE_TIMEOUT)) idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: what to emit this cycle and which FIFO to pop.
  always_comb begin
    emit      = 1'b0;
    emit_char = '0;
    pop       = '0;
    case (state_q)
      PFX_ID: if (!buffer_full) begin
        emit      = 1'b1;
        emit_char = DATA_WIDTH'(hex_to_ascii(4'(grant_q)));
      end
      PFX_COL: if (!buffer_full) begin
        emit      = 1'b1;
        emit_char = DATA_WIDTH'(ASCII_COLON);
      end
      STREAM: if (!grant_empty && !buffer_full) begin
        emit         = 1'b1;
        emit_char    = grant_data;
        pop[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // State, arbitration and registered output; data holds when idle.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      valid_q    <= emit;
      ovf_q      <= ovf_d;
      if (emit) data_q <= emit_char;
    end
  end

endmodule

// File: tb/tb_debug_stream_merger.sv
// Directed bench for debug_stream_merger: expected characters are queued
// as stimulus is issued; a monitor pops and compares on every output pulse.
module tb_debug_stream_merger;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [27:0] ascii_c_in;
  logic [3:0]  ascii_s_in;
  logic [6:0]  data_out;
  logic        data_out_valid;
  logic        buffer_full;
  logic [3:0]  overflow;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [6:0]  exp_q[$];
  int          vt_q[$];
  logic [6:0]  mon_exp;

  debug_stream_merger #(
    .CHANNELS(4), .DATA_WIDTH(7), .FIFO_DEPTH(4), .EOL_CHAR(7'h0A),
    .IDLE_TIMEOUT(8), .PREFIX_EN(1'b1)
  ) dut (
    .clk(clk), .res_n(res_n), .ascii_c_in(ascii_c_in), .ascii_s_in(ascii_s_in),
    .data_out(data_out), .data_out_valid(data_out_valid), .buffer_full(buffer_full),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (res_n && data_out_valid) begin
      vt_q.push_back(cyc);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got=%0h expected=none", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_out !== mon_exp) begin
          bad++;
          $display("FAIL out_char: got=%0h expected=%0h", data_out, mon_exp);
        end
      end
    end
  end

  task automatic expect_str(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      exp_q.push_back(b[6:0]);
    end
  endtask

  task automatic strobe1(input int ch, input byte c);
    ascii_c_in[ch*7 +: 7] = c[6:0];
    ascii_s_in[ch] = 1'b1;
    @(negedge clk);
    ascii_s_in = '0;
  endtask

  task automatic strobe2(input int a, input byte ca, input int b, input byte cb);
    ascii_c_in[a*7 +: 7] = ca[6:0];
    ascii_c_in[b*7 +: 7] = cb[6:0];
    ascii_s_in[a] = 1'b1;
    ascii_s_in[b] = 1'b1;
    @(negedge clk);
    ascii_s_in = '0;
  endtask

  task automatic strobe_str(input int ch, input string s);
    for (int i = 0; i < s.len(); i++) strobe1(ch, s[i]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, busy}, 0);
  endtask

  task automatic wait_char(input string name, input logic [6:0] c, input int budget);
    int n;
    n = 0;
    while (!(data_out_valid && data_out == c) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'b0, data_out_valid}, 1);
  endtask

  initial begin
    int t0;
    int cnt;
    ascii_c_in  = '0;
    ascii_s_in  = '0;
    buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);
    res_n = 1'b1;
    @(negedge clk);

    // 1: single line with prefix, latency and back-to-back output
    vt_q.delete();
    expect_str("0:hi\n");
    t0 = cyc + 1;
    strobe_str(0, "hi\n");
    wait_drain("t1_drain", 20);
    check("t1_first_lat", vt_q[0], t0 + 2);
    check("t1_last_lat", vt_q[4], t0 + 6);
    wait_idle("t1_idle", 10);

    // 2: simultaneous lines do not interleave; rr pointer wraps to ch1
    for (int r = 0; r < 2; r++) begin
      expect_str("1:ab\n2:cd\n");
      strobe2(1, "a", 2, "c");
      strobe2(1, "b", 2, "d");
      strobe2(1, "\n", 2, "\n");
      wait_drain("t2_drain", 30);
      wait_idle("t2_idle", 10);
    end

    // 3: FIFO overflow under backpressure
    buffer_full = 1'b1;
    expect_str("3:ABCD");
    strobe_str(3, "ABCDEF");
    @(negedge clk);
    check("t3_ovf", overflow, 4'b1000);
    check("t3_stall_no_out", exp_q.size(), 6);
    buffer_full = 1'b0;
    wait_drain("t3_drain", 20);
    wait_idle("t3_timeout_idle", 30);

    // 4: open line loses grant after idle timeout
    vt_q.delete();
    expect_str("0:x1:y\n");
    strobe2(0, "x", 1, "y");
    strobe1(1, "\n");
    wait_drain("t4_drain", 40);
    check("t4_gap", (vt_q[3] - vt_q[2]) >= 9, 1);
    wait_idle("t4_idle", 10);

    // 5: mid-line stall keeps order and loses nothing
    expect_str("2:mn\n");
    strobe_str(2, "mn\n");
    wait_char("t5_saw_m", 7'h6D, 10);
    buffer_full = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(data_out_valid);
    end
    check("t5_stall_quiet", cnt, 0);
    buffer_full = 1'b0;
    wait_drain("t5_drain", 20);
    wait_idle("t5_idle", 10);

    // 6: asynchronous reset mid-line
    expect_str("0:kl");
    strobe_str(0, "kl");
    wait_char("t6_saw_l", 7'h6C, 10);
    check("t6_busy_before", busy, 1);
    #1 res_n = 1'b0;
    #1;
    check("t6_valid", data_out_valid, 0);
    check("t6_ovf", overflow, 0);
    check("t6_busy", busy, 0);
    check("t6_data", data_out, 0);
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(data_out_valid);
    end
    check("t6_quiet", cnt, 0);
    check("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
